// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode/function encodings, instruction field positions
// and the fetch-unit state encoding. Imported by control_unit and instr_fetch_unit.
package isa_pkg;

  localparam int INSTR_W = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int FUNCT_MSB  = 3;
  localparam int FUNCT_LSB  = 0;

  localparam logic [4:0] OP_AR   = 5'b00010;
  localparam logic [4:0] OP_T    = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_XOR = 4'b0100;
  localparam logic [3:0] FN_NOR = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b0110;
  localparam logic [3:0] FN_SLL = 4'b0111;
  localparam logic [3:0] FN_SRL = 4'b1000;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_t;

  function automatic logic [4:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [3:0] get_funct(input logic [INSTR_W-1:0] word);
    return word[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus: the fetch unit is the master,
// the memory the slave. At most one request is outstanding at a time.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment; increment
// wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples the pre-edge values of its inputs.
  always_ff @(posedge CLK) begin
    if (RST)       pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch unit: one request in flight, instruction held until the
// control unit accepts it, redirects override everything, HALT parks the unit.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  instr_fetch_unit_if.master   imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 instr_valid,
  output logic [INSTR_W-1:0]   instr,
  output logic [4:0]           opcode,
  output logic [3:0]           funct,
  output logic [ADDR_W-1:0]    pc_out,
  output logic                 halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;

  assign pc_inc = (state == ST_ISSUE) && !stall;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .CLK      (CLK),
    .RST      (RST),
    .load     (redirect),
    .load_val (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign opcode = get_opcode(instr);
  assign funct  = get_funct(instr);

  // Entering FETCH raises req together with the address the PC will hold,
  // so FETCH always lasts exactly the one request cycle. The only FETCH
  // without req is the first cycle after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_FETCH;
      imem.req    <= 1'b0;
      imem.addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          if (imem.req) begin
            imem.req <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            imem.req  <= 1'b1;
            imem.addr <= redirect_pc;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (imem.rvalid) begin
            imem.req  <= 1'b1;
            imem.addr <= redirect_pc;
            state     <= ST_FETCH;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_ISSUE, ST_HALTED: begin
          imem.req  <= 1'b1;
          imem.addr <= redirect_pc;
          state     <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (imem.req) begin
            imem.req <= 1'b0;
            state    <= ST_WAIT;
          end else begin
            imem.req  <= 1'b1;
            imem.addr <= pc;
          end
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            instr  <= imem.rdata;
            pc_out <= pc;
            if (get_opcode(imem.rdata) == OP_HALT) begin
              halted <= 1'b1;
              state  <= ST_HALTED;
            end else begin
              instr_valid <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            imem.req    <= 1'b1;
            imem.addr   <= pc + 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem.rvalid) begin
            imem.req  <= 1'b1;
            imem.addr <= pc;
            state     <= ST_FETCH;
          end
        end
        ST_HALTED: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch unit that produces the opcode and function fields consumed by `control_unit`. It holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/response handshake, and presents the decoded fields to the control unit until they are accepted. It also handles branch redirects and a HALT opcode, and sits between instruction memory and the control/ALU datapath.

## Interface
- `ADDR_W`, 16: instruction memory word-address width; the PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value loaded on reset.
- `CLK` input 1: single clock; all logic on posedge.
- `RST` input 1: reset is synchronous and active-high.
- `imem_req` output 1: fetch request, one-cycle pulse.
- `imem_addr` output ADDR_W: word address, valid while `imem_req` is high.
- `imem_rvalid` input 1: response valid; arrives 1 or more cycles after `imem_req`.
- `imem_rdata` input 32: instruction word, sampled when `imem_rvalid` is high.
- `stall` input 1: downstream not ready; the issued instruction is held.
- `redirect` input 1: branch taken; restart fetch at `redirect_pc`.
- `redirect_pc` input ADDR_W: target word address.
- `instr_valid` output 1: `instr`, `opcode`, `funct` and `pc_out` are valid.
- `instr` output 32: full instruction word.
- `opcode` output 5: `instr[31:27]`.
- `funct` output 4: `instr[3:0]`, meaningful for R-type instructions only.
- `pc_out` output ADDR_W: address of the issued instruction.
- `halted` output 1: the fetch unit is stopped on HALT.

## Operation
- **States:** FETCH, WAIT, ISSUE, DRAIN, HALTED.
- **FETCH:**
  - Drive `imem_req=1` and `imem_addr=pc` for exactly one cycle, then go to WAIT.
- **WAIT:**
  - On `imem_rvalid`, latch `imem_rdata` into the instruction register and latch `pc_out<=pc`.
  - If `imem_rdata[31:27]==OP_HALT` (5'b11111), go to HALTED. The HALT instruction is not issued.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `instr_valid=1`; all outputs are held stable while `stall=1`.
  - On the first cycle with `stall=0`, the instruction is accepted: `pc<=pc+1` (wrapping) and the next state is FETCH.
- **Redirect** has priority over every other event in every state:
  - Set `pc<=redirect_pc` and `instr_valid<=0`.
  - From FETCH or WAIT where the issued request has not yet responded: go to DRAIN.
  - From WAIT with `imem_rvalid` high in the same cycle: the response is discarded; go to FETCH.
  - From ISSUE or HALTED: go to FETCH. `halted` clears.
- **DRAIN:**
  - Wait for `imem_rvalid`, discard the data, then go to FETCH.
  - A further redirect while in DRAIN only updates `pc`.
- **Outstanding requests:** at most one at any time. `imem_req` is never asserted in WAIT, DRAIN, ISSUE or HALTED.
- **HALTED:**
  - `halted=1` and `instr_valid=0`; no requests are issued.
  - Only `redirect` or `RST` leaves this state.
- **Wrap-around:** `pc` = 2^ADDR_W−1 advances to 0 with no flag.

## Timing
- **Reset values:** `state=FETCH`, `pc=RESET_PC`, `imem_req=0`, `imem_addr=0`, `instr_valid=0`, `instr=0`, `opcode=0`, `funct=0`, `pc_out=0`, `halted=0`.
- **First request:** `imem_req` rises in the first cycle after `RST` deasserts.
- **Reset mid-operation:** `RST` high during any state forces the reset values on the next edge. A memory response arriving after reset while in FETCH is ignored.
- **Latency:** with a memory latency of 1, `req`@t, `rvalid`@t+1, `instr_valid`@t+2. The next `req` is @t+3 if `stall=0`. Steady-state throughput is 1 instruction per 3 cycles.
- **Acceptance:** `instr_valid` drops in the cycle after acceptance and in the cycle after a redirect.
- **Control unit handoff:** `control_unit` samples `opcode` on the posedge where `instr_valid && !stall`.

## Structure
- **Package `isa_pkg`** contains:
  - opcode constants: `OP_AR=5'b00010`, `OP_T=5'b01011`, `OP_HALT=5'b11111`;
  - function codes 4'b0000–4'b1000 (ADD..SRL);
  - field bit positions;
  - the fetch state enum.
  
  `control_unit` and `instr_fetch_unit` both import it.
- **Sub-module `pc_reg`:** holds the ADDR_W register with inputs `load`, `load_val` and `inc`, and synchronous reset to `RESET_PC`.

## Test plan
- **Reset and first fetches:** after reset, memory latency 1, words AR (0x10000000) then T (0x58000000), `stall=0` → `imem_addr` 0 then 1; `opcode` 5'b00010 then 5'b01011; `instr_valid` pulses one cycle each, 3 cycles apart.
- **Stall:** `stall=1` for 4 cycles during ISSUE → `instr`/`pc_out` held; no `imem_req`; `pc` advances only after `stall` falls.
- **Redirect with a response outstanding:** redirect to 0x0040 while in WAIT with memory latency 3 → the pending response is discarded; the next `imem_req` carries address 0x0040; no `instr_valid` for the discarded word.
- **HALT and resume:** HALT word at address 5 → `halted=1`, no further requests for 10 cycles; then redirect to 0 → fetch resumes at 0 and `halted=0`.
- **Wrap-around:** `RESET_PC=16'hFFFF` → the second fetch address is 0x0000.
- **Synchronous reset mid-ISSUE with `stall=1`** → next cycle `instr_valid=0` and `pc=RESET_PC`; `imem_req` rises the cycle after `RST` falls.
